// File: rtl/nn_pkg.sv
// Shared FP32 definitions for the NN core and its downstream consumers.
// fp_order_key maps FP32 bits onto an unsigned integer with the same ordering as the
// floating-point values, so magnitude compares need no FP hardware.
package nn_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned FP_EXP_W = 8;
    localparam int unsigned FP_SIG_W = 23;

    // Negative values: invert all bits so larger magnitude sorts lower.
    // Positive values: flip the sign bit so they sort above every negative.
    // -0 ends up just below +0; NaN/Inf simply follow their bit patterns.
    function automatic logic [FP_W-1:0] fp_order_key(input logic [FP_W-1:0] bits);
        logic [FP_W-1:0] sign_mask;
        sign_mask = {1'b1, {(FP_W-1){1'b0}}};
        return bits[FP_W-1] ? ~bits : (bits ^ sign_mask);
    endfunction

endpackage

// File: rtl/nn_res_fifo.sv
// Small result FIFO with a registered head word.
// Pointers carry one extra wrap bit to tell full from empty. A push into an empty FIFO
// is visible at the head one cycle later; there is no combinational bypass.
module nn_res_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_head;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic [AW:0]      w_wr_next;
    logic [AW:0]      w_rd_next;
    logic [WIDTH-1:0] w_head_next;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head  = r_head;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop_ok  = i_pop & ~o_empty;
    assign w_push_ok = i_push & (~o_full | w_pop_ok);
    assign w_wr_next = r_wr_ptr + {{AW{1'b0}}, w_push_ok};
    assign w_rd_next = r_rd_ptr + {{AW{1'b0}}, w_pop_ok};

    // Next head: the incoming word if it lands in the head slot, else the stored entry.
    always_comb begin
        w_head_next = r_head;
        if (w_rd_next != w_wr_next) begin
            if (w_push_ok && (w_rd_next == r_wr_ptr)) begin
                w_head_next = i_data;
            end else begin
                w_head_next = r_mem[w_rd_next[AW-1:0]];
            end
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Pointer and head register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            r_head   <= w_head_next;
        end
    end

endmodule

// File: rtl/nn_out_argmax.sv
// Per-time-step argmax over the NN core's serial FP32 output stream.
// Every VEC_LEN accepted samples form one group; the winning {idx, max, step} is pushed
// into a result FIFO combinationally on the group's last sample, so it is at the FIFO
// head one cycle later.
module nn_out_argmax
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W     = FP_W,
    parameter int unsigned VEC_LEN    = 3,
    parameter int unsigned NUM_STEP   = 3,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_W      = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
    parameter int unsigned STEP_W     = (NUM_STEP > 1) ? $clog2(NUM_STEP) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_max,
    output logic [STEP_W-1:0] out_step,
    output logic              overflow
);

    localparam int unsigned RES_W = IDX_W + DATA_W + STEP_W;

    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_max;
    logic [STEP_W-1:0] r_step;
    logic              r_ovf;

    logic              w_last;
    logic              w_take;
    logic [IDX_W-1:0]  w_idx_next;
    logic [DATA_W-1:0] w_max_next;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [RES_W-1:0]  w_res;
    logic [RES_W-1:0]  w_head;

    // Sample 0 always loads; later samples must be strictly greater, so ties keep
    // the lower index.
    always_comb begin
        w_last     = (r_cnt == IDX_W'(VEC_LEN - 1));
        w_take     = (r_cnt == '0) || (fp_order_key(in_data) > fp_order_key(r_max));
        w_idx_next = w_take ? r_cnt : r_idx;
        w_max_next = w_take ? in_data : r_max;
        w_push     = in_valid & w_last;
        w_res      = {w_idx_next, w_max_next, r_step};
    end

    // Sample counter, running max and step counter; all hold across in_valid gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_max  <= '0;
            r_step <= '0;
        end else if (in_valid) begin
            r_idx <= w_idx_next;
            r_max <= w_max_next;
            if (w_last) begin
                r_cnt  <= '0;
                r_step <= (r_step == STEP_W'(NUM_STEP - 1)) ? '0 : r_step + STEP_W'(1);
            end else begin
                r_cnt <= r_cnt + IDX_W'(1);
            end
        end
    end

    // Sticky overflow: a completed result found the FIFO full with no pop to make room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    assign w_pop = out_valid & out_ready;

    nn_res_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_res),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign out_valid = ~w_empty;
    assign out_idx   = w_head[RES_W-1 -: IDX_W];
    assign out_max   = w_head[STEP_W +: DATA_W];
    assign out_step  = w_head[STEP_W-1:0];
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_nn_out_argmax.sv
// Directed bench for nn_out_argmax: inputs change 1 ns after the rising edge and
// outputs are checked at that same point, i.e. in the cycle following the edge.
module tb_nn_out_argmax;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_idx;
    logic [31:0] out_max;
    logic [1:0]  out_step;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    nn_out_argmax dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_max   (out_max),
        .out_step  (out_step),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted sample, preceded by 'gap' idle cycles.
    task automatic send(input logic [31:0] d, input int gap);
        for (int g = 0; g < gap; g++) tick();
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        send(a, 0);
        send(b, 0);
        send(c, 0);
    endtask

    task automatic check_head(input string tag, input logic [1:0] idx, input logic [31:0] mx,
                              input logic [1:0] step);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd1);
        check_eq({tag, ".idx"},   64'(out_idx),   64'(idx));
        check_eq({tag, ".max"},   64'(out_max),   64'(mx));
        check_eq({tag, ".step"},  64'(out_step),  64'(step));
    endtask

    // Check the head, then accept it with a one-cycle out_ready pulse.
    task automatic expect_pop(input string tag, input logic [1:0] idx, input logic [31:0] mx,
                              input logic [1:0] step);
        check_head(tag, idx, mx, step);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, ".idx"},   64'(out_idx),   64'd0);
        check_eq({tag, ".max"},   64'(out_max),   64'd0);
        check_eq({tag, ".step"},  64'(out_step),  64'd0);
        check_eq({tag, ".ovf"},   64'(overflow),  64'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [31:0] t5_data [12] = '{32'h40000000, 32'h40800000, 32'h3F000000,
                                  32'hC1200000, 32'hC1000000, 32'hC0A00000,
                                  32'h7F800000, 32'h42C80000, 32'h7F800000,
                                  32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E4CCCCD};
    int          t5_gap  [12] = '{0, 2, 1, 0, 3, 0, 1, 0, 2, 0, 0, 1};
    logic [1:0]  t5_idx  [4]  = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [31:0] t5_max  [4]  = '{32'h40800000, 32'hC0A00000, 32'h7F800000, 32'h3E4CCCCD};
    logic [1:0]  t5_step [4]  = '{2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        // Reset state.
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: basic argmax, one-cycle latency.
        send3(32'h3F800000, 32'h40400000, 32'h40000000);
        expect_pop("t1", 2'd1, 32'h40400000, 2'd0);
        check_eq("t1.empty", 64'(out_valid), 64'd0);

        // 2: negatives, then -0 vs +0.
        send3(32'hBF800000, 32'hBF000000, 32'hC0000000);
        expect_pop("t2a", 2'd1, 32'hBF000000, 2'd1);
        send3(32'h80000000, 32'h00000000, 32'h80000000);
        expect_pop("t2b", 2'd1, 32'h00000000, 2'd2);

        // 3: ties keep the lower index; step has wrapped.
        send3(32'h40000000, 32'h40000000, 32'h3F800000);
        expect_pop("t3a", 2'd0, 32'h40000000, 2'd0);
        send3(32'h3F800000, 32'h40000000, 32'h40000000);
        expect_pop("t3b", 2'd1, 32'h40000000, 2'd1);

        // 4: five back-to-back groups with out_ready low; the fifth is dropped.
        do_reset();
        send3(32'h40400000, 32'h3F800000, 32'h40000000);
        send3(32'h3F800000, 32'h40A00000, 32'h40000000);
        send3(32'h3F800000, 32'h40000000, 32'h40E00000);
        send3(32'hC0000000, 32'hBF800000, 32'hC0400000);
        check_eq("t4.ovf_before", 64'(overflow), 64'd0);
        check_head("t4.hold", 2'd0, 32'h40400000, 2'd0);
        send3(32'h41000000, 32'h41100000, 32'h41200000);
        check_eq("t4.ovf_set", 64'(overflow), 64'd1);
        expect_pop("t4.p0", 2'd0, 32'h40400000, 2'd0);
        expect_pop("t4.p1", 2'd1, 32'h40A00000, 2'd1);
        expect_pop("t4.p2", 2'd2, 32'h40E00000, 2'd2);
        expect_pop("t4.p3", 2'd1, 32'hBF800000, 2'd0);
        check_eq("t4.drained", 64'(out_valid), 64'd0);
        check_eq("t4.ovf_sticky", 64'(overflow), 64'd1);

        // 5: gaps in in_valid, consumer always ready.
        do_reset();
        check_eq("t5.ovf_cleared", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(t5_data[i], t5_gap[i]);
            if (i % 3 == 2) check_head($sformatf("t5.g%0d", i / 3), t5_idx[i / 3],
                                       t5_max[i / 3], t5_step[i / 3]);
        end
        tick();
        check_eq("t5.drained", 64'(out_valid), 64'd0);

        // 6: reset mid-group discards the partial group.
        do_reset();
        out_ready = 1'b0;
        send(32'h40000000, 0);
        send(32'h41000000, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6.inrst");
        tick();
        rst_n = 1'b1;
        tick();
        send3(32'h3F800000, 32'hBF800000, 32'h3F000000);
        expect_pop("t6", 2'd0, 32'h3F800000, 2'd0);
        check_eq("t6.empty", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
